pipeline_sequencer: RTL

Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards and applies EX-stage redirects (taken branch, JAL, JALR). It freezes the pipeline while data memory is not ready, and drains the pipeline on HALT. It also keeps saturating stall and flush counters for debug. It consumes decoded stage fields and drives the PC and pipeline-register enable/flush controls.

---
 rtl/pipeline_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush/halt control for a 5-stage RISC-V pipeline with saturating debug counters.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_BR = 7'b1100011, OP_I = 7'b0010011, OP_JALR = 7'b1100111,
                         OP_HALT = 7'b1111111;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t state, next;
  logic [DW-1:0] drain_q, drain_d;
  logic uses_rs1, uses_rs2, hazard, mem_wait, redirect_taken;
  assign uses_rs1 = id_opcode inside {OP_R, OP_LOAD, OP_STORE, OP_BR, OP_I, OP_JALR};
  assign uses_rs2 = id_opcode inside {OP_R, OP_STORE, OP_BR};
  assign hazard = ex_memread && ex_rd != 5'd0 &&
                  ((uses_rs1 && ex_rd == id_rs1) || (uses_rs2 && ex_rd == id_rs2));
  assign mem_wait = mem_access && !mem_ready;
  assign halted = state == HALTED;
  always_comb begin
    next = state;
    drain_d = drain_q;
    redirect_taken = 1'b0;
    pc_write = 1'b1;
    ifid_write = 1'b1;
    exmem_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    memwb_flush = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          {pc_write, ifid_write, exmem_write, memwb_flush} = 4'b0001;
          next = MEM_WAIT;
        end else if (ex_redirect) begin
          {ifid_flush, idex_flush} = 2'b11;
          redirect_taken = 1'b1;
        end else if (hazard) begin
          {pc_write, ifid_write, idex_flush} = 3'b001;
        end else if (id_opcode == OP_HALT) begin
          {pc_write, ifid_write, idex_flush} = 3'b001;
          drain_d = DW'(DRAIN_CYCLES - 1);
          next = DRAIN;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) {pc_write, ifid_write, exmem_write, memwb_flush} = 4'b0001;
        else next = RUN;
      end
      DRAIN: begin
        {pc_write, ifid_write} = 2'b00;
        if (mem_wait) {exmem_write, memwb_flush} = 2'b01;
        else begin
          idex_flush = 1'b1;
          next = drain_q == '0 ? HALTED : DRAIN;
          drain_d = drain_q == '0 ? drain_q : drain_q - 1'b1;
        end
      end
      default: {pc_write, ifid_write, exmem_write, idex_flush, memwb_flush} = 5'b00011;
    endcase
    if (!rst_n) begin
      {pc_write, ifid_write, exmem_write} = 3'b000;
      {ifid_flush, idex_flush, memwb_flush} = 3'b111;
      redirect_taken = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      drain_q <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= next;
      drain_q <= drain_d;
      if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (redirect_taken && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule
